miss_replacement_controller: RTL and testbench
==============================================

# miss_replacement_controller

Cache-miss sequencer that consumes the per-set victim way produced by the set-associative replacement block, writes back a dirty victim, refills the line from the bus, and then commits the new tag. It drives the CPU-side index and access-update inputs of the replacement block, closing the loop so the refilled way becomes most-recently used. It sits between the CPU-side miss detector and the shared bus/arbiter.

## Interface
- INDEX_WIDTH, 6, set index width; must equal the replacement block's INDEX_WIDTH.
- NUMBER_OF_CACHE_LINES, 4, ways per set.
- COUNTER_WIDTH, $clog2(NUMBER_OF_CACHE_LINES), way-select width.
- TAG_WIDTH, 8, tag width.
- OFFSET_WIDTH, 4, word-offset width; a line holds W = 2^OFFSET_WIDTH words.
- DATA_WIDTH, 32, word width.
- Ports (ADDRESS_WIDTH = TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH):
- clock  in  1  the single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low; forces IDLE immediately.
- missValid / missAddress  in  1 / ADDRESS_WIDTH  miss request; missReady  out  1  high only in IDLE.
- cpuIndexOut  out  INDEX_WIDTH  captured index, goes to replacement cpuIndexIn.
- replacementCacheLine  in  COUNTER_WIDTH  victim way for cpuIndexOut.
- accessEnable  out  1; lastAccessedCacheLine  out  COUNTER_WIDTH  update to the replacement block.
- victimWayOut  out  COUNTER_WIDTH  latched victim way; addresses the tag/data arrays.
- victimValid, victimDirty  in  1; victimTag  in  TAG_WIDTH  tag-array state at (cpuIndexOut, victimWayOut).
- cacheWordOffset  out  OFFSET_WIDTH; cacheReadData  in  DATA_WIDTH  combinational array read.
- cacheWriteEnable  out  1; cacheWriteData  out  DATA_WIDTH  refill word write.
- tagWriteEnable  out  1; tagWriteValue  out  TAG_WIDTH  writes the tag, sets valid, clears dirty.
- busRequest, busWrite  out  1; busGrant, busAck  in  1.
- busAddress  out  ADDRESS_WIDTH; busDataOut  out  DATA_WIDTH; busDataIn  in  DATA_WIDTH.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, SELECT, CHECK, WB_REQ, WB_DATA, RELEASE, FILL_REQ, FILL_DATA, COMMIT.
- IDLE: missValid && missReady latches tag and index and zeroes the word counter. Next state is SELECT. missValid is ignored in any other state.
- SELECT: latch replacementCacheLine into victimWayOut. Next state is CHECK.
- CHECK: victimValid && victimDirty goes to WB_REQ; otherwise FILL_REQ.
- WB_REQ: busRequest=1. On busGrant, go to WB_DATA.
- WB_DATA: busRequest=1, busWrite=1, busAddress={victimTag, index, counter}, busDataOut=cacheReadData, cacheWordOffset=counter.
  - Each busAck increments the counter (mod W).
  - The ack on word W-1 goes to RELEASE with the counter at 0.
- RELEASE: busRequest=0 for exactly one cycle. Next state is FILL_REQ.
- FILL_REQ: busRequest=1, busWrite=0. On busGrant, go to FILL_DATA.
- FILL_DATA: busRequest=1, busAddress={missTag, index, counter}.
  - In each busAck cycle, cacheWriteEnable=1, cacheWriteData=busDataIn, cacheWordOffset=counter.
  - The counter then increments; the ack on word W-1 goes to COMMIT.
- COMMIT (one cycle): tagWriteEnable=1, tagWriteValue=missTag, accessEnable=1, lastAccessedCacheLine=victimWayOut, done=1. Next state is IDLE.
- busAck outside WB_DATA/FILL_DATA is ignored. busGrant is sampled only in WB_REQ/FILL_REQ.
- A clean or invalid victim skips writeback entirely.
- Reset at any point: state IDLE, counter 0, all latched fields 0, every pulse/bus output 0, missReady=1. A partially filled line is not committed.

## Timing
- Reset values: missReady=1; all other outputs 0, including cpuIndexOut, victimWayOut and busAddress.
- The acceptance edge is cycle 0.
- Clean miss, immediate grant, ack every cycle: FILL_REQ at cycle 3, FILL_DATA cycles 4..3+W, COMMIT/done at cycle 4+W (20 for W=16).
- Dirty miss, same bus: WB_DATA cycles 4..3+W, RELEASE at 4+W, FILL_REQ at 5+W, FILL_DATA 6+W..5+2W, done at 6+2W (38 for W=16).
- Each grant wait or ack gap adds exactly one cycle.
- All outputs are registered or state-decoded; cacheWriteData and busDataOut pass through combinationally.
- missReady rises in the cycle after COMMIT, so back-to-back misses are accepted one cycle apart.

## Test plan
- Clean miss (W=16), index 5, victim way 2 invalid, grant/ack immediate -> no busWrite ever, 16 cacheWriteEnable pulses at offsets 0..15, done at cycle 20 with tagWriteEnable=1 and lastAccessedCacheLine=2.
- Dirty victim, tag 0x3C, way 1 -> 16 write beats at busAddress {0x3C, idx, 0..15} with array data, busRequest low for exactly one cycle, then 16 fill beats; done at cycle 38.
- Stall injection: grant delayed 3 cycles, ack every other cycle -> word order and data unchanged; done delayed by exactly the added cycles.
- missValid held high during a busy miss -> second miss accepted only after returning to IDLE; spurious busAck in IDLE/CHECK -> no counter change.
- Reset asserted mid FILL_DATA (word 7) -> outputs zero asynchronously, missReady=1, no tagWriteEnable; the next miss refills from word 0.
- Two consecutive misses to different indices -> accessEnable pulses once per miss with the correct cpuIndexOut and way.

Source files
------------

// File: rtl/miss_replacement_controller.sv
// Cache-miss sequencer: picks the victim way, writes back a dirty line, refills
// the line from the bus, then commits the tag and marks the way most-recently used.
module miss_replacement_controller #(
  parameter int INDEX_WIDTH = 6,
  parameter int NUMBER_OF_CACHE_LINES = 4,
  parameter int COUNTER_WIDTH = $clog2(NUMBER_OF_CACHE_LINES),
  parameter int TAG_WIDTH = 8,
  parameter int OFFSET_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  localparam int ADDRESS_WIDTH = TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     missValid,
  input  logic [ADDRESS_WIDTH-1:0] missAddress,
  output logic                     missReady,
  output logic [INDEX_WIDTH-1:0]   cpuIndexOut,
  input  logic [COUNTER_WIDTH-1:0] replacementCacheLine,
  output logic                     accessEnable,
  output logic [COUNTER_WIDTH-1:0] lastAccessedCacheLine,
  output logic [COUNTER_WIDTH-1:0] victimWayOut,
  input  logic                     victimValid,
  input  logic                     victimDirty,
  input  logic [TAG_WIDTH-1:0]     victimTag,
  output logic [OFFSET_WIDTH-1:0]  cacheWordOffset,
  input  logic [DATA_WIDTH-1:0]    cacheReadData,
  output logic                     cacheWriteEnable,
  output logic [DATA_WIDTH-1:0]    cacheWriteData,
  output logic                     tagWriteEnable,
  output logic [TAG_WIDTH-1:0]     tagWriteValue,
  output logic                     busRequest,
  output logic                     busWrite,
  input  logic                     busGrant,
  input  logic                     busAck,
  output logic [ADDRESS_WIDTH-1:0] busAddress,
  output logic [DATA_WIDTH-1:0]    busDataOut,
  input  logic [DATA_WIDTH-1:0]    busDataIn,
  output logic                     done,
  output logic [3:0]               debugState
);

  typedef enum logic [3:0] {
    IDLE, SELECT, CHECK, WB_REQ, WB_DATA, RELEASE, FILL_REQ, FILL_DATA, COMMIT
  } state_t;

  localparam logic [OFFSET_WIDTH-1:0] LAST_WORD = {OFFSET_WIDTH{1'b1}};

  state_t                   state_q;
  logic [TAG_WIDTH-1:0]     tag_q;
  logic [INDEX_WIDTH-1:0]   index_q;
  logic [COUNTER_WIDTH-1:0] way_q;
  logic [OFFSET_WIDTH-1:0]  count_q;

  logic unused_offset;
  assign unused_offset = ^missAddress[OFFSET_WIDTH-1:0];

  // Handshakes: a miss is taken on an edge where missValid && missReady; a bus
  // tenure starts on the edge busGrant is seen in a *_REQ state, and one word moves
  // on every edge busAck is seen in a *_DATA state. Neither is looked at elsewhere.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tag_q   <= '0;
      index_q <= '0;
      way_q   <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (missValid) begin
            tag_q   <= missAddress[ADDRESS_WIDTH-1 -: TAG_WIDTH];
            index_q <= missAddress[OFFSET_WIDTH +: INDEX_WIDTH];
            count_q <= '0;
            state_q <= SELECT;
          end
        end
        SELECT: begin
          way_q   <= replacementCacheLine;
          state_q <= CHECK;
        end
        CHECK:    state_q <= (victimValid && victimDirty) ? WB_REQ : FILL_REQ;
        WB_REQ:   if (busGrant) state_q <= WB_DATA;
        WB_DATA: begin
          if (busAck) begin
            count_q <= count_q + 1'b1;
            if (count_q == LAST_WORD) state_q <= RELEASE;
          end
        end
        RELEASE:  state_q <= FILL_REQ;
        FILL_REQ: if (busGrant) state_q <= FILL_DATA;
        FILL_DATA: begin
          if (busAck) begin
            count_q <= count_q + 1'b1;
            if (count_q == LAST_WORD) state_q <= COMMIT;
          end
        end
        COMMIT:   state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

  logic in_wb, in_fill, in_commit;
  assign in_wb     = (state_q == WB_DATA);
  assign in_fill   = (state_q == FILL_DATA);
  assign in_commit = (state_q == COMMIT);

  assign missReady   = (state_q == IDLE);
  assign cpuIndexOut = index_q;
  assign victimWayOut = way_q;
  assign debugState  = state_q;

  assign busRequest = (state_q == WB_REQ) || in_wb || (state_q == FILL_REQ) || in_fill;
  assign busWrite   = in_wb;
  // Writeback addresses the victim's old tag; refill addresses the missing tag.
  assign busAddress = in_wb   ? {victimTag, index_q, count_q} :
                      in_fill ? {tag_q, index_q, count_q} : '0;
  assign busDataOut = in_wb ? cacheReadData : '0;

  assign cacheWordOffset  = (in_wb || in_fill) ? count_q : '0;
  assign cacheWriteEnable = in_fill && busAck;
  assign cacheWriteData   = in_fill ? busDataIn : '0;

  assign tagWriteEnable        = in_commit;
  assign tagWriteValue         = in_commit ? tag_q : '0;
  assign accessEnable          = in_commit;
  assign lastAccessedCacheLine = in_commit ? way_q : '0;
  assign done                  = in_commit;

endmodule

// File: tb/tb_miss_replacement_controller.sv
// Directed bench for miss_replacement_controller: models the tag/data arrays and a
// bus slave with grant/ack stalls; a scoreboard queue checks every beat and commit.
module tb_miss_replacement_controller;
  localparam int IW = 6, CW = 2, TW = 8, OW = 4, DW = 32, AW = 18, W = 16;
  localparam int EW = 2 + AW + DW;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          missValid = 1'b0;
  logic [AW-1:0] missAddress = '0;
  logic          missReady;
  logic [IW-1:0] cpuIndexOut;
  logic [CW-1:0] replacementCacheLine = '0;
  logic          accessEnable;
  logic [CW-1:0] lastAccessedCacheLine;
  logic [CW-1:0] victimWayOut;
  logic          victimValid = 1'b0;
  logic          victimDirty = 1'b0;
  logic [TW-1:0] victimTag = '0;
  logic [OW-1:0] cacheWordOffset;
  logic [DW-1:0] cacheReadData;
  logic          cacheWriteEnable;
  logic [DW-1:0] cacheWriteData;
  logic          tagWriteEnable;
  logic [TW-1:0] tagWriteValue;
  logic          busRequest, busWrite;
  logic          busGrant = 1'b0;
  logic          busAck = 1'b0;
  logic [AW-1:0] busAddress;
  logic [DW-1:0] busDataOut;
  logic [DW-1:0] busDataIn;
  logic          done;
  logic [3:0]    debugState;

  miss_replacement_controller dut (
    .clock(clock), .reset(reset),
    .missValid(missValid), .missAddress(missAddress), .missReady(missReady),
    .cpuIndexOut(cpuIndexOut), .replacementCacheLine(replacementCacheLine),
    .accessEnable(accessEnable), .lastAccessedCacheLine(lastAccessedCacheLine),
    .victimWayOut(victimWayOut), .victimValid(victimValid), .victimDirty(victimDirty),
    .victimTag(victimTag), .cacheWordOffset(cacheWordOffset), .cacheReadData(cacheReadData),
    .cacheWriteEnable(cacheWriteEnable), .cacheWriteData(cacheWriteData),
    .tagWriteEnable(tagWriteEnable), .tagWriteValue(tagWriteValue),
    .busRequest(busRequest), .busWrite(busWrite), .busGrant(busGrant), .busAck(busAck),
    .busAddress(busAddress), .busDataOut(busDataOut), .busDataIn(busDataIn),
    .done(done), .debugState(debugState)
  );

  // ---------------- clock / counters ----------------
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- array and memory models ----------------
  function automatic logic [DW-1:0] arr_word(input logic [IW-1:0] idx, input logic [CW-1:0] way,
                                             input logic [OW-1:0] off);
    return {8'hA5, 2'b00, idx, 6'h00, way, 4'h0, off};
  endfunction

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {14'h2A5, a};
  endfunction

  assign cacheReadData = arr_word(cpuIndexOut, victimWayOut, cacheWordOffset);
  assign busDataIn     = mem_word(busAddress);

  // ---------------- bus slave ----------------
  int   grant_delay = 0;
  int   ack_gap = 0;
  logic spur_ack = 1'b0;
  logic granted = 1'b0;
  int   wcnt = 0;
  int   acnt = 0;

  always @(posedge clock) begin
    #2;
    if (!busRequest) begin
      granted  = 1'b0;
      wcnt     = 0;
      acnt     = 0;
      busGrant = 1'b0;
      busAck   = spur_ack;
    end else begin
      if (busGrant) granted = 1'b1;
      if (!granted) begin
        busGrant = (wcnt >= grant_delay);
        wcnt++;
        busAck = 1'b0;
      end else begin
        busGrant = 1'b0;
        busAck = ((acnt % (ack_gap + 1)) == ack_gap);
        acnt++;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    logic [EW-1:0] obs;
    logic have;
    have = 1'b0;
    obs = '0;
    if (busRequest && busAck) begin
      have = 1'b1;
      if (busWrite) obs = {2'd1, busAddress, busDataOut};
      else begin
        obs = {2'd2, busAddress, cacheWriteData};
        chk("fill_we", 64'(cacheWriteEnable), 64'd1);
        chk("fill_offset", 64'(cacheWordOffset), 64'(busAddress[OW-1:0]));
      end
    end else begin
      chk("stray_we", 64'(cacheWriteEnable), 64'd0);
      if (tagWriteEnable || accessEnable || done) begin
        have = 1'b1;
        obs = {2'd3, tagWriteValue, cpuIndexOut, lastAccessedCacheLine, 2'b00,
               29'd0, tagWriteEnable, accessEnable, done};
      end
    end
    if (have) begin
      if (exp_q.size() == 0) chk("sb_unexpected", 64'(obs), 64'd0);
      else chk("sb_event", 64'(obs), 64'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_victim(input logic [CW-1:0] way, input logic vv, input logic vd,
                            input logic [TW-1:0] vtag);
    replacementCacheLine = way;
    victimValid = vv;
    victimDirty = vd;
    victimTag = vtag;
  endtask

  task automatic push_miss(input logic [TW-1:0] tag, input logic [IW-1:0] idx,
                           input logic [CW-1:0] way, input logic vv, input logic vd,
                           input logic [TW-1:0] vtag);
    logic [AW-1:0] a;
    if (vv && vd)
      for (int w = 0; w < W; w++) begin
        a = {vtag, idx, 4'(w)};
        exp_q.push_back({2'd1, a, arr_word(idx, way, 4'(w))});
      end
    for (int w = 0; w < W; w++) begin
      a = {tag, idx, 4'(w)};
      exp_q.push_back({2'd2, a, mem_word(a)});
    end
    exp_q.push_back({2'd3, tag, idx, way, 2'b00, 29'd0, 3'b111});
  endtask

  // Ends just after the acceptance edge (cycle 0).
  task automatic accept(input logic [TW-1:0] tag, input logic [IW-1:0] idx, input logic hold);
    int b;
    @(negedge clock);
    missValid = 1'b1;
    missAddress = {tag, idx, 4'h9};
    b = 0;
    while (!missReady && b < 200) begin @(negedge clock); b++; end
    chk("accept_ready", 64'(missReady), 64'd1);
    @(posedge clock);
    #1;
    if (!hold) missValid = 1'b0;
  endtask

  task automatic wait_done(input int lat, input string tag);
    int n;
    n = 0;
    do begin @(negedge clock); n++; end while (!done && n < lat + 200);
    chk(tag, 64'(n), 64'(lat));
  endtask

  task automatic run_miss(input logic [TW-1:0] tag, input logic [IW-1:0] idx,
                          input logic [CW-1:0] way, input logic vv, input logic vd,
                          input logic [TW-1:0] vtag, input int lat, input string tag_s);
    set_victim(way, vv, vd, vtag);
    push_miss(tag, idx, way, vv, vd, vtag);
    accept(tag, idx, 1'b0);
    wait_done(lat, tag_s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    #3;
    chk("rst_missReady", 64'(missReady), 64'd1);
    chk("rst_busRequest", 64'(busRequest), 64'd0);
    chk("rst_busAddress", 64'(busAddress), 64'd0);
    chk("rst_cpuIndex", 64'(cpuIndexOut), 64'd0);
    chk("rst_victimWay", 64'(victimWayOut), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    @(negedge clock);
    reset = 1'b1;

    // Clean miss, invalid victim (dirty bit set but line invalid => no writeback).
    run_miss(8'h11, 6'd5, 2'd2, 1'b0, 1'b1, 8'h77, 20, "clean_latency");
    // Dirty victim, tag 0x3C, way 1.
    run_miss(8'h77, 6'd9, 2'd1, 1'b1, 1'b1, 8'h3C, 38, "dirty_latency");

    // Grant delayed 3 cycles per request, ack every other cycle.
    grant_delay = 3;
    ack_gap = 1;
    run_miss(8'h5A, 6'h21, 2'd0, 1'b1, 1'b1, 8'hC3, 76, "stall_latency");
    grant_delay = 0;
    ack_gap = 0;

    // missValid held through a busy miss, with spurious acks outside data phases.
    spur_ack = 1'b1;
    set_victim(2'd3, 1'b1, 1'b0, 8'h99);
    push_miss(8'hE1, 6'h3F, 2'd3, 1'b1, 1'b0, 8'h99);
    push_miss(8'hE1, 6'h3F, 2'd3, 1'b1, 1'b0, 8'h99);
    accept(8'hE1, 6'h3F, 1'b1);
    n = 0;
    do begin
      @(negedge clock); n++;
      if (n == 5) chk("busy_not_ready", 64'(missReady), 64'd0);
    end while (!done && n < 300);
    chk("held_first_latency", 64'(n), 64'd20);
    @(negedge clock); n++;
    chk("b2b_ready", 64'(missReady), 64'd1);
    do begin @(negedge clock); n++; end while (!done && n < 300);
    chk("held_second_latency", 64'(n), 64'd41);
    missValid = 1'b0;
    spur_ack = 1'b0;

    // Reset in the middle of the refill at word 7.
    set_victim(2'd2, 1'b0, 1'b0, 8'h00);
    push_miss(8'h6B, 6'h12, 2'd2, 1'b0, 1'b0, 8'h00);
    accept(8'h6B, 6'h12, 1'b0);
    for (int i = 0; i < 11; i++) @(negedge clock);
    chk("pre_reset_offset", 64'(cacheWordOffset), 64'd7);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_missReady", 64'(missReady), 64'd1);
    chk("mid_rst_busRequest", 64'(busRequest), 64'd0);
    chk("mid_rst_busAddress", 64'(busAddress), 64'd0);
    chk("mid_rst_cacheWe", 64'(cacheWriteEnable), 64'd0);
    chk("mid_rst_tagWe", 64'(tagWriteEnable), 64'd0);
    chk("mid_rst_cpuIndex", 64'(cpuIndexOut), 64'd0);
    chk("mid_rst_victimWay", 64'(victimWayOut), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    run_miss(8'h6B, 6'h12, 2'd2, 1'b0, 1'b0, 8'h00, 20, "post_reset_latency");

    // Two consecutive misses to different indices and ways.
    run_miss(8'h01, 6'h01, 2'd0, 1'b1, 1'b0, 8'h10, 20, "consec1_latency");
    run_miss(8'hF0, 6'h30, 2'd3, 1'b1, 1'b1, 8'h0F, 38, "consec2_latency");

    repeat (3) @(negedge clock);
    chk("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
